// File: rtl/fir4_share_sched.sv
// Round-robin shared 4-tap unit-coefficient FIR sum engine for NCH channels.
// Optional macro FIR_PRIME_EN: suppress outputs until a channel's history is full.
module fir4_share_sched #(
    parameter int W   = 16,
    parameter int NCH = 4,
    localparam int CW = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH*W-1:0] in_data,
    output logic [NCH-1:0]   in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W+1:0]     out_sum,
    output logic [CW-1:0]    out_ch
);

    // Handshake: a sample transfers on channel i when in_valid[i] & in_ready[i];
    // a result transfers when out_valid & out_ready. in_ready never waits on itself.

    logic [W-1:0]  h0_q [NCH];
    logic [W-1:0]  h1_q [NCH];
    logic [W-1:0]  h2_q [NCH];
    logic [W-1:0]  h0_d [NCH];
    logic [W-1:0]  h1_d [NCH];
    logic [W-1:0]  h2_d [NCH];
    logic [CW-1:0] ptr_q, ptr_d;
    logic          out_valid_q, out_valid_d;
    logic [W+1:0]  out_sum_q, out_sum_d;
    logic [CW-1:0] out_ch_q, out_ch_d;

    logic          stage_free;
    logic          gnt_any;
    logic [CW-1:0] gnt_id;
    logic [W-1:0]  gnt_data;
    logic [W+1:0]  sum_full;
    logic          emit;

    always_comb begin : grant_logic
        int idx;
        stage_free = !out_valid_q || out_ready;
        gnt_any    = 1'b0;
        gnt_id     = '0;
        idx        = 0;
        if (stage_free && !flush) begin
            for (int k = 0; k < NCH; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NCH) idx = idx - NCH;
                if (!gnt_any && in_valid[idx]) begin
                    gnt_any = 1'b1;
                    gnt_id  = CW'(idx);
                end
            end
        end
        in_ready = gnt_any ? (NCH'(1) << gnt_id) : '0;
    end

    always_comb begin
        gnt_data = in_data[gnt_id*W +: W];
        sum_full = {2'b00, gnt_data} + {2'b00, h0_q[gnt_id]}
                 + {2'b00, h1_q[gnt_id]} + {2'b00, h2_q[gnt_id]};
    end

`ifdef FIR_PRIME_EN
    logic [1:0] fill_q [NCH];
    logic [1:0] fill_d [NCH];

    always_comb begin
        fill_d = fill_q;
        if (flush) begin
            for (int i = 0; i < NCH; i++) fill_d[i] = 2'd0;
        end else if (gnt_any && fill_q[gnt_id] != 2'd3) begin
            fill_d[gnt_id] = fill_q[gnt_id] + 2'd1;
        end
        emit = gnt_any && (fill_q[gnt_id] == 2'd3);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) fill_q[i] <= 2'd0;
        end else begin
            fill_q <= fill_d;
        end
    end
`else
    always_comb emit = gnt_any;
`endif

    always_comb begin
        h0_d = h0_q;
        h1_d = h1_q;
        h2_d = h2_q;
        if (flush) begin
            for (int i = 0; i < NCH; i++) begin
                h0_d[i] = '0;
                h1_d[i] = '0;
                h2_d[i] = '0;
            end
        end else if (gnt_any) begin
            h0_d[gnt_id] = gnt_data;
            h1_d[gnt_id] = h0_q[gnt_id];
            h2_d[gnt_id] = h1_q[gnt_id];
        end
        ptr_d = ptr_q;
        if (gnt_any) ptr_d = (gnt_id == CW'(NCH - 1)) ? '0 : gnt_id + 1'b1;
    end

    // A suppressed (priming) grant still empties the stage, like a no-grant cycle.
    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ch_d    = out_ch_q;
        if (stage_free) begin
            out_valid_d = emit;
            if (emit) begin
                out_sum_d = sum_full;
                out_ch_d  = gnt_id;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                h0_q[i] <= '0;
                h1_q[i] <= '0;
                h2_q[i] <= '0;
            end
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ch_q    <= '0;
        end else begin
            h0_q        <= h0_d;
            h1_q        <= h1_d;
            h2_q        <= h2_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_fir4_share_sched.sv
// Directed bench for fir4_share_sched: expected results queued on accept,
// popped and compared by an independent output monitor.
module tb_fir4_share_sched;

    localparam int W   = 16;
    localparam int NCH = 4;
    localparam int CW  = $clog2(NCH);
    localparam int EW  = CW + W + 2;

    logic             clk;
    logic             reset;
    logic [NCH-1:0]   in_valid;
    logic [NCH*W-1:0] in_data;
    logic [NCH-1:0]   in_ready;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [W+1:0]     out_sum;
    logic [CW-1:0]    out_ch;

    logic [EW-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    int fill [NCH];

    fir4_share_sched #(.W(W), .NCH(NCH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ch    (out_ch)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Decides whether an accepted sample should produce a result.
    function automatic bit take_grant(input int ch);
        bit e;
`ifdef FIR_PRIME_EN
        e = (fill[ch] >= 3);
        if (fill[ch] < 3) fill[ch]++;
`else
        e = 1'b1;
`endif
        return e;
    endfunction

    task automatic clear_fill();
        for (int i = 0; i < NCH; i++) fill[i] = 0;
    endtask

    // Driver: called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int ch, input logic [W-1:0] d, input logic [W+1:0] s);
        logic got;
        bit   e;
        got = 1'b0;
        in_valid[ch] = 1'b1;
        in_data[ch*W +: W] = d;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (in_ready[ch]) got = 1'b1;
        end
        check("accept_timeout", {31'd0, got}, 32'd1);
        if (!got) begin
            in_valid[ch] = 1'b0;
            return;
        end
        e = take_grant(ch);
        if (e) exp_q.push_back({CW'(ch), s});
        @(posedge clk);
        #1;
        in_valid[ch] = 1'b0;
        if (e) begin
            check("latency_valid", {31'd0, out_valid}, 32'd1);
            check("latency_ch", {{(32-CW){1'b0}}, out_ch}, ch);
        end
    endtask

    // scoreboard monitor
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (reset && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output: ch=%0d sum=0x%0h with empty queue", out_ch, out_sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_ch, out_sum} !== e) begin
                        failures++;
                        $display("FAIL output: got ch=%0d sum=0x%0h, expected ch=%0d sum=0x%0h",
                                 out_ch, out_sum, e[EW-1 -: CW], e[W+1:0]);
                    end
                end
            end
        end
    end

    logic [W+1:0] single_exp [5] = '{18'd1, 18'd3, 18'd6, 18'd10, 18'd14};
    logic [W+1:0] max_exp    [4] = '{18'h0FFFF, 18'h1FFFE, 18'h2FFFD, 18'h3FFFC};
    int           rr_ch      [6] = '{0, 1, 2, 3, 0, 1};
    logic [W+1:0] rr_exp     [6] = '{18'd1, 18'd2, 18'd3, 18'd4, 18'd2, 18'd4};
    logic [W+1:0] fl_exp     [4] = '{18'd1, 18'd3, 18'd6, 18'd10};

    initial begin
        reset     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        clear_fill();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", {14'd0, out_sum}, 32'd0);
        check("rst_out_ch", {{(32-CW){1'b0}}, out_ch}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {28'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;

        // single channel 1..5
        for (int i = 0; i < 5; i++) send(0, W'(i + 1), single_exp[i]);

        // max value on ch2
        for (int i = 0; i < 4; i++) send(2, 16'hFFFF, max_exp[i]);

        // backpressure: 3FFFC held, ch3 waits; ptr is 3 so ch3 wins on release
        out_ready = 1'b0;
        in_valid[3] = 1'b1;
        in_data[3*W +: W] = 16'd9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", {28'd0, in_ready}, 32'd0);
            check("bp_out_sum", {14'd0, out_sum}, 32'h3FFFC);
            check("bp_out_ch", {{(32-CW){1'b0}}, out_ch}, 32'd2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant", {28'd0, in_ready}, 32'b1000);
        if (in_ready[3] && take_grant(3)) exp_q.push_back({CW'(3), 18'd9});
        @(posedge clk);
        #1;
        in_valid[3] = 1'b0;
        @(posedge clk);
        #1;

        // asynchronous reset while a result is pending (6+5+4+3)
        send(0, 16'd6, 18'd18);
        out_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_sum", {14'd0, out_sum}, 32'd0);
        exp_q.delete();
        clear_fill();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {28'd0, in_ready}, 32'd0);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // round robin, all channels valid; ch i sends i+1
        for (int i = 0; i < NCH; i++) in_data[i*W +: W] = W'(i + 1);
        in_valid = '1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rr_grant", {28'd0, in_ready}, 32'd1 << rr_ch[i]);
            if (in_ready[rr_ch[i]] && take_grant(rr_ch[i]))
                exp_q.push_back({CW'(rr_ch[i]), rr_exp[i]});
        end
        @(posedge clk);
        #1;
        in_valid = '0;

        // ch1 holds history 2,2: 7+2+2, then 7+7+2+2
        send(1, 16'd7, 18'd11);
        send(1, 16'd7, 18'd18);

        // flush with ch1 requesting: no grant, pending result still drains
        flush = 1'b1;
        in_valid[1] = 1'b1;
        in_data[1*W +: W] = 16'd1;
        @(negedge clk);
        check("flush_in_ready", {28'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        clear_fill();
        for (int i = 0; i < 4; i++) send(1, W'(i + 1), fl_exp[i]);

        // drain
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
